wm8731_i2s_adc_receiver: RTL
============================

// Module: wm8731_i2s_adc_receiver
// PURPOSE
//  I2S receiver for the WM8731 ADC path: captures ADCDAT serial audio against the BCLK/ADCLRC
//  clocks produced by the codec driver and delivers parallel left/right sample pairs.
//  Sits between codec pins and the synth DSP/record logic. Complements the DAC-side transmitter.
// PARAMETERS
//  DATA_WIDTH   16  bits captured per channel slot, MSB first
//  SYNC_STAGES  2   flip-flop stages on BCLK/ADCLRC/ADCDAT into the CLOCK50M domain (>=2)
// PORTS
//  CLOCK50M       in   1           sole clock, 50 MHz system clock
//  RESET          in   1           asynchronous, active-low reset
//  BCLK           in   1           I2S bit clock (raw pin/driver output), <= CLOCK50M/8
//  ADCLRC         in   1           I2S channel select: 0 = left, 1 = right; left is first
//  ADCDAT         in   1           I2S serial data from the codec ADC
//  left_sample    out  DATA_WIDTH  last complete left word
//  right_sample   out  DATA_WIDTH  last complete right word
//  sample_valid   out  1           pair available; held until accepted
//  sample_ready   in   1           consumer accepts pair when valid & ready
//  overrun        out  1           one-cycle pulse: new pair overwrote an unaccepted pair
//  frame_error    out  1           sticky: slot ended before DATA_WIDTH bits captured
//  err_clear      in   1           synchronous clear of frame_error
//  overrun_count  out  8           saturating overrun count (OVERRUN_COUNT_EN only)
// BEHAVIOUR
//  - Reset (RESET=0, async): all outputs 0, shift reg/bit count 0, state WAIT_SYNC.
//  - BCLK/ADCLRC/ADCDAT pass SYNC_STAGES flops; BCLK rise detected from synced prev/curr pair.
//    All capture happens only on synced BCLK rising-edge strobes (one CLOCK50M cycle each).
//  - On each strobe sample lrc and dat together. "LRC edge" = sampled lrc != previous sampled lrc.
//  - FSM: WAIT_SYNC -> SHIFT on first LRC edge (no partial words after reset).
//    SHIFT: bit index k counts strobes after LRC edge (edge strobe is k=0, its dat ignored:
//    I2S one-bit delay); k=1..DATA_WIDTH shift dat in MSB first. At k=DATA_WIDTH word done,
//    -> HOLD. HOLD: further bits ignored (slot longer than DATA_WIDTH allowed) until LRC edge
//    -> SHIFT with k=0. LRC edge while in SHIFT (k<DATA_WIDTH): discard word, set frame_error,
//    clear left_ok, restart SHIFT at k=0 for new slot.
//  - Left word done (lrc=0): latch to internal left buffer, set left_ok.
//    Right word done (lrc=1) with left_ok: update left_sample/right_sample, assert sample_valid
//    next cycle, clear left_ok. Right word without left_ok: dropped silently.
//  - Latency: sample_valid rises SYNC_STAGES+2 CLOCK50M cycles after raw BCLK rise carrying
//    right LSB (bench tolerance +1 for sync phase).
//  - Handshake: valid&ready clears sample_valid next cycle; outputs stable while valid&!ready.
//    New pair while valid & !ready: outputs overwritten, valid stays 1, overrun pulses 1 cycle.
//    New pair same cycle as acceptance: accept old, load new, valid stays 1, no overrun.
//  - err_clear and a new frame error same cycle: frame_error stays 1 (set wins).
// CONFIGURATION
//  - OVERRUN_COUNT_EN defined: overrun_count port exists; +1 per overrun pulse, saturates 255,
//    reset-only clear. Undefined: port and counter absent; overrun pulse unaffected.
// STRUCTURE
//  - Shared package wm8731_pkg: DEFAULT_DATA_WIDTH=16, LRC_LEFT=1'b0/LRC_RIGHT=1'b1,
//    receiver state encodings (WAIT_SYNC, SHIFT, HOLD).
//  - Sub-module wm8731_sync_edge: parameterised synchroniser + rising-edge strobe, instanced
//    for BCLK (strobe) and plain-sync for ADCLRC/ADCDAT.
// TESTING (DATA_WIDTH=16, BCLK=CLOCK50M/16, 32 BCLK per frame, ready tied 1 unless stated)
//  1 Reset mid-slot: RESET low during right slot -> all outputs 0 at once; no pair until
//    first full left+right after an LRC edge.
//  2 Nominal: left 16'hFAFA, right 16'h8F8F -> one valid pulse, left_sample=FAFA,
//    right_sample=8F8F, latency within spec.
//  3 Backpressure: ready=0 for 2 frames (L/R 0001/0002 then 0003/0004) -> outputs 0003/0004,
//    valid held, overrun pulses once (overrun_count=1 with OVERRUN_COUNT_EN).
//  4 Short slot: LRC toggles after 10 left bits -> frame_error=1, no pair that frame; next
//    good frame delivers normally; err_clear drops frame_error.
//  5 Long slot/start mid-frame: 24 BCLK slots, bench starts in right slot -> only top 16 bits
//    captured, first pair comes from first complete left+right.
//  6 Saturation (OVERRUN_COUNT_EN): 300 overruns -> overrun_count=255.

Source files
------------

// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 codec interface blocks: default word width,
// ADCLRC channel encodings and the I2S receiver state set.
package wm8731_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  localparam logic LRC_LEFT  = 1'b0;
  localparam logic LRC_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT     = 2'd1,
    HOLD      = 2'd2
  } rx_state_t;

endpackage

// File: rtl/wm8731_sync_edge.sv
// Multi-flop synchroniser for a bundle of asynchronous pins, with an optional
// one-cycle rising-edge strobe derived from the synchronised level.
module wm8731_sync_edge #(
  parameter int WIDTH       = 1,
  parameter int STAGES      = 2,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
    end
  end

  assign dout = chain[STAGES-1];

  generate
    if (EDGE_DETECT) begin : g_edge
      logic [WIDTH-1:0] prev;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev <= '0;
        end else begin
          prev <= dout;
        end
      end

      assign rise = dout & ~prev;
    end else begin : g_level
      assign rise = '0;
    end
  endgenerate

endmodule

// File: rtl/wm8731_i2s_adc_receiver.sv
// I2S receiver for the WM8731 ADC path: captures ADCDAT on synchronised BCLK rises
// and delivers left/right pairs with a valid/ready handshake.
// Optional feature macro: OVERRUN_COUNT_EN adds a saturating overrun_count output.
module wm8731_i2s_adc_receiver
  import wm8731_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK50M,
  input  logic                  RESET,
  input  logic                  BCLK,
  input  logic                  ADCLRC,
  input  logic                  ADCDAT,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_error,
  input  logic                  err_clear
`ifdef OVERRUN_COUNT_EN
  ,
  output logic [7:0]            overrun_count
`endif
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic            unused_bclk_level;
  logic            bclk_rise;
  logic [1:0]      lrc_dat_s;
  logic [1:0]      unused_lrc_dat_rise;
  logic            lrc_s;
  logic            dat_s;

  rx_state_t       state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic            word_done;
  logic            slot_err;

  logic            lrc_last;
  logic            lrc_primed;
  logic            lrc_edge;
  logic            left_ok;
  logic            pair_pend;
  logic [DATA_WIDTH-1:0] left_buf;
  logic [DATA_WIDTH-1:0] right_buf;

  wm8731_sync_edge #(
    .WIDTH      (1),
    .STAGES     (SYNC_STAGES),
    .EDGE_DETECT(1'b1)
  ) u_bclk_sync (
    .clk  (CLOCK50M),
    .rst_n(RESET),
    .din  (BCLK),
    .dout (unused_bclk_level),
    .rise (bclk_rise)
  );

  // LRC and data share an identical chain so they stay aligned with the BCLK strobe.
  wm8731_sync_edge #(
    .WIDTH      (2),
    .STAGES     (SYNC_STAGES),
    .EDGE_DETECT(1'b0)
  ) u_lrc_dat_sync (
    .clk  (CLOCK50M),
    .rst_n(RESET),
    .din  ({ADCLRC, ADCDAT}),
    .dout (lrc_dat_s),
    .rise (unused_lrc_dat_rise)
  );

  assign lrc_s = lrc_dat_s[1];
  assign dat_s = lrc_dat_s[0];

  // The first strobe after reset only records LRC, so a mid-slot release is never an edge.
  assign lrc_edge = bclk_rise && lrc_primed && (lrc_s != lrc_last);

  always_ff @(posedge CLOCK50M or negedge RESET) begin
    if (!RESET) begin
      state <= WAIT_SYNC;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shreg_nx  = shreg;
    word_done = 1'b0;
    slot_err  = 1'b0;
    if (bclk_rise) begin
      unique case (state)
        WAIT_SYNC: begin
          if (lrc_edge) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
          end
        end
        SHIFT: begin
          if (lrc_edge) begin
            slot_err = 1'b1;
            cnt_nx   = '0;
          end else begin
            shreg_nx = {shreg[DATA_WIDTH-2:0], dat_s};
            if (cnt == CW'(DATA_WIDTH - 1)) begin
              word_done = 1'b1;
              state_nx  = HOLD;
              cnt_nx    = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (lrc_edge) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = WAIT_SYNC;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK50M or negedge RESET) begin
    if (!RESET) begin
      lrc_last     <= 1'b0;
      lrc_primed   <= 1'b0;
      left_ok      <= 1'b0;
      pair_pend    <= 1'b0;
      left_buf     <= '0;
      right_buf    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      pair_pend <= 1'b0;

      if (bclk_rise) begin
        lrc_last   <= lrc_s;
        lrc_primed <= 1'b1;
      end

      if (slot_err) begin
        left_ok <= 1'b0;
      end

      if (word_done) begin
        if (lrc_s == LRC_LEFT) begin
          left_buf <= shreg_nx;
          left_ok  <= 1'b1;
        end else if (lrc_s == LRC_RIGHT && left_ok) begin
          right_buf <= shreg_nx;
          left_ok   <= 1'b0;
          pair_pend <= 1'b1;
        end
      end

      // A pair landing while the old one is being accepted is not an overrun.
      if (pair_pend) begin
        left_sample  <= left_buf;
        right_sample <= right_buf;
        sample_valid <= 1'b1;
        overrun      <= sample_valid & ~sample_ready;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (slot_err) begin
        frame_error <= 1'b1;
      end else if (err_clear) begin
        frame_error <= 1'b0;
      end
    end
  end

`ifdef OVERRUN_COUNT_EN
  always_ff @(posedge CLOCK50M or negedge RESET) begin
    if (!RESET) begin
      overrun_count <= '0;
    end else if (pair_pend && sample_valid && !sample_ready && overrun_count != 8'hFF) begin
      overrun_count <= overrun_count + 8'd1;
    end
  end
`endif

endmodule
